// File: rtl/traffic_pkg.sv
// Shared types for the two-street traffic light controller.
package traffic_pkg;

    // Light code driven onto each street; 2'b11 is never produced.
    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    // Controller states, binary encoded.
    typedef enum logic [1:0] {
        S0 = 2'd0,  // A green, B red
        S1 = 2'd1,  // A yellow, B red
        S2 = 2'd2,  // A red, B green
        S3 = 2'd3   // A red, B yellow
    } state_t;

    localparam int unsigned DwellWidth = 8;

    // True for the states whose duration is set by the dwell timer.
    function automatic logic is_yellow(input state_t s);
        return (s == S1) || (s == S3);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts cycles spent in a yellow phase and flags when the last cycle is reached.
module dwell_timer
    import traffic_pkg::*;
#(
    parameter int unsigned YELLOW_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic done_o,
    output logic ovf_o
);

    logic [DwellWidth-1:0] cnt_q;
    logic [DwellWidth-1:0] cnt_d;

    // Next count: clear wins over enable; holds when idle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == DwellWidth'(YELLOW_CYCLES - 1));
    // Can only be reached if the counter is corrupted; the FSM recovers to S0.
    assign ovf_o  = (cnt_q == {DwellWidth{1'b1}});

endmodule

// File: rtl/traffic_lights_fsm.sv
// Moore controller for a two-street intersection with sensor-held green phases.
module traffic_lights_fsm
    import traffic_pkg::*;
#(
    parameter int unsigned YELLOW_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TA,
    input  logic       TB,
    output logic [1:0] LA,
    output logic [1:0] LB
);

    state_t state_q;
    state_t state_d;
    logic   dwell_done;
    logic   dwell_ovf;
    logic   dwell_clear;
    logic   dwell_en;
    light_t la;
    light_t lb;

    // Restart the dwell count whenever the state moves so each yellow starts at zero.
    assign dwell_clear = (state_d != state_q);
    assign dwell_en    = is_yellow(state_q);

    dwell_timer #(
        .YELLOW_CYCLES(YELLOW_CYCLES)
    ) u_dwell_timer (
        .clk    (clk),
        .reset  (reset),
        .clear_i(dwell_clear),
        .en_i   (dwell_en),
        .done_o (dwell_done),
        .ovf_o  (dwell_ovf)
    );

    // Next-state logic; each sensor matters only in its own green state.
    always_comb begin
        state_d = state_q;
        if (dwell_ovf) begin
            state_d = S0;
        end else begin
            unique case (state_q)
                S0:      state_d = TA ? S0 : S1;
                S1:      state_d = dwell_done ? S2 : S1;
                S2:      state_d = TB ? S2 : S3;
                S3:      state_d = dwell_done ? S0 : S3;
                default: state_d = S0;
            endcase
        end
    end

    // State register; reset has priority over every transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode from the state register only.
    always_comb begin
        la = RED;
        lb = RED;
        unique case (state_q)
            S0:      begin la = GREEN;  lb = RED;    end
            S1:      begin la = YELLOW; lb = RED;    end
            S2:      begin la = RED;    lb = GREEN;  end
            S3:      begin la = RED;    lb = YELLOW; end
            default: begin la = RED;    lb = RED;    end
        endcase
    end

    assign LA = la;
    assign LB = lb;

endmodule

// File: tb/tb_traffic_lights_fsm.sv
// Self-checking bench: table-driven run on a YELLOW_CYCLES=1 instance plus
// hand sequences for sensor hold and a YELLOW_CYCLES=3 instance.
module tb_traffic_lights_fsm;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, ta1, tb1;
    logic [1:0] la1, lb1;
    logic       rst3, ta3, tb3;
    logic [1:0] la3, lb3;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;

    traffic_lights_fsm #(.YELLOW_CYCLES(1)) dut1 (
        .clk  (clk),
        .reset(rst1),
        .TA   (ta1),
        .TB   (tb1),
        .LA   (la1),
        .LB   (lb1)
    );

    traffic_lights_fsm #(.YELLOW_CYCLES(3)) dut3 (
        .clk  (clk),
        .reset(rst3),
        .TA   (ta3),
        .TB   (tb3),
        .LA   (la3),
        .LB   (lb3)
    );

    typedef struct {
        logic       rst;
        logic       ta;
        logic       tb;
        logic [1:0] la;
        logic [1:0] lb;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [1:0] la, input logic [1:0] lb,
                         input logic [1:0] exp_la, input logic [1:0] exp_lb);
        checks++;
        if (la !== exp_la || lb !== exp_lb) begin
            failures++;
            $display("FAIL %s: got LA=%b LB=%b, expected LA=%b LB=%b",
                     name, la, lb, exp_la, exp_lb);
        end
    endtask

    // Drive dut1 at the falling edge, check 1 time unit after the rising edge.
    task automatic step1(input logic r, input logic a, input logic b,
                         input logic [1:0] exp_la, input logic [1:0] exp_lb, input string name);
        @(negedge clk);
        rst1 = r; ta1 = a; tb1 = b;
        @(posedge clk);
        #1;
        check(name, la1, lb1, exp_la, exp_lb);
    endtask

    task automatic step3(input logic r, input logic a, input logic b,
                         input logic [1:0] exp_la, input logic [1:0] exp_lb, input string name);
        @(negedge clk);
        rst3 = r; ta3 = a; tb3 = b;
        @(posedge clk);
        #1;
        check(name, la3, lb3, exp_la, exp_lb);
    endtask

    // Safety monitor: never both green, never the unused code.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((la1 == G && lb1 == G) || (la3 == G && lb3 == G) ||
                la1 == 2'b11 || lb1 == 2'b11 || la3 == 2'b11 || lb3 == 2'b11) begin
                failures++;
                $display("FAIL safety: dut1 LA=%b LB=%b dut3 LA=%b LB=%b, required no double green",
                         la1, lb1, la3, lb3);
            end
        end
    end

    initial begin
        rst1 = 1'b1; ta1 = 1'b0; tb1 = 1'b0;
        rst3 = 1'b1; ta3 = 1'b0; tb3 = 1'b0;

        // {reset, TA, TB, expected LA, expected LB} after each edge
        vecs.push_back('{1'b1, 1'b0, 1'b0, G, R});  // reset
        vecs.push_back('{1'b0, 1'b0, 1'b0, Y, R});  // idle cycling
        vecs.push_back('{1'b0, 1'b0, 1'b0, R, G});
        vecs.push_back('{1'b0, 1'b0, 1'b0, R, Y});
        vecs.push_back('{1'b0, 1'b0, 1'b0, G, R});
        vecs.push_back('{1'b0, 1'b0, 1'b0, Y, R});
        vecs.push_back('{1'b0, 1'b0, 1'b0, R, G});
        vecs.push_back('{1'b0, 1'b0, 1'b0, R, Y});  // in S3
        vecs.push_back('{1'b1, 1'b0, 1'b0, G, R});  // mid-sequence reset
        vecs.push_back('{1'b0, 1'b1, 1'b0, G, R});  // TA holds S0
        vecs.push_back('{1'b0, 1'b1, 1'b1, G, R});
        vecs.push_back('{1'b0, 1'b0, 1'b1, Y, R});  // TA drop -> S1
        vecs.push_back('{1'b0, 1'b1, 1'b0, R, G});  // sensors ignored in S1
        vecs.push_back('{1'b0, 1'b1, 1'b1, R, G});  // TB holds S2
        vecs.push_back('{1'b0, 1'b0, 1'b1, R, G});
        vecs.push_back('{1'b0, 1'b1, 1'b0, R, Y});  // TB drop -> S3
        vecs.push_back('{1'b0, 1'b1, 1'b1, G, R});  // sensors ignored in S3
        vecs.push_back('{1'b0, 1'b0, 1'b0, Y, R});
        vecs.push_back('{1'b1, 1'b0, 1'b1, G, R});  // reset from S1

        @(posedge clk);
        #1;
        mon_en = 1'b1;
        foreach (vecs[i]) begin
            step1(vecs[i].rst, vecs[i].ta, vecs[i].tb, vecs[i].la, vecs[i].lb,
                  $sformatf("vec%0d", i));
        end

        // Long sensor hold on both green phases.
        for (int i = 0; i < 10; i++) step1(1'b0, 1'b1, 1'b0, G, R, "hold_a");
        step1(1'b0, 1'b0, 1'b0, Y, R, "drop_a");
        step1(1'b0, 1'b0, 1'b1, R, G, "enter_b");
        for (int i = 0; i < 10; i++) step1(1'b0, 1'b0, 1'b1, R, G, "hold_b");
        step1(1'b0, 1'b0, 1'b0, R, Y, "drop_b");
        step1(1'b0, 1'b0, 1'b0, G, R, "back_s0");

        // YELLOW_CYCLES=3: each yellow lasts exactly three cycles.
        step3(1'b1, 1'b0, 1'b0, G, R, "y3_reset");
        for (int i = 0; i < 3; i++) step3(1'b0, 1'b0, 1'b0, Y, R, "y3_s1");
        step3(1'b0, 1'b0, 1'b0, R, G, "y3_s2");
        for (int i = 0; i < 3; i++) step3(1'b0, 1'b1, 1'b0, R, Y, "y3_s3");
        step3(1'b0, 1'b0, 1'b0, G, R, "y3_s0");
        // Reset mid-yellow must restart the dwell count from zero.
        step3(1'b0, 1'b0, 1'b0, Y, R, "y3_s1b");
        step3(1'b0, 1'b0, 1'b1, Y, R, "y3_s1c");
        step3(1'b1, 1'b0, 1'b0, G, R, "y3_midreset");
        for (int i = 0; i < 3; i++) step3(1'b0, 1'b0, 1'b1, Y, R, "y3_s1_again");
        step3(1'b0, 1'b0, 1'b1, R, G, "y3_s2_again");

        @(negedge clk);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
